// File: rtl/wishbone_sram_responder.sv
// Wishbone classic-cycle slave backed by a word-addressed SRAM, with
// configurable wait states, byte-lane writes and error responses outside the window.
`timescale 1ns/1ps
module wishbone_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  input  logic [3:0]  wb_sel,
  input  logic        wb_we,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic [31:0] wb_dat_r,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        busy
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [3:0]       wait_cnt;
  logic             req;
  logic [31:0]      offset;
  logic             in_range;
  logic             unused_adr_lsb;
  logic [IDX_W-1:0] idx_p0;
  logic [31:0]      dat_p0;
  logic [3:0]       sel_p0;
  logic             we_p0;
  logic             in_range_p0;
  logic             commit;
  logic             wr_en;
  logic             rd_en;
  logic [31:0]      mem [DEPTH_WORDS];

  assign req            = wb_cyc & wb_stb;
  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign offset         = wb_adr - BASE_ADDR;
  assign in_range       = (offset >> 2) < 32'(DEPTH_WORDS);
  assign unused_adr_lsb = ^offset[1:0];

  // A response only takes effect if the master still holds the cycle.
  assign commit = (state == S_RESP) && wb_cyc && in_range_p0;
  assign wr_en  = commit && we_p0;
  assign rd_en  = commit && !we_p0;

  // Request capture stage (p0)
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      idx_p0      <= offset[IDX_W+1:2];
      dat_p0      <= wb_dat_w;
      sel_p0      <= wb_sel;
      we_p0       <= wb_we;
      in_range_p0 <= in_range;
    end
  end

  // Memory access stage: write commit and registered read share the response edge
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_p0[i]) mem[idx_p0][8*i +: 8] <= dat_p0[8*i +: 8];
      end
    end
    if (rst)        wb_dat_r <= '0;
    else if (rd_en) wb_dat_r <= mem[idx_p0];
    else            wb_dat_r <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      wb_ack   <= 1'b0;
      wb_err   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      wb_ack <= 1'b0;
      wb_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            wait_cnt <= WAIT_INIT;
            busy     <= 1'b1;
            state    <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (!wb_cyc) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            busy     <= 1'b0;
          end else if (wait_cnt <= 4'd1) begin
            state    <= S_RESP;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (wb_cyc) begin
            wb_ack <= in_range_p0;
            wb_err <= !in_range_p0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_sram_responder.sv
// Bench for wishbone_sram_responder: one instance with two wait states and one
// with none, checked against an associative-array memory model.
`timescale 1ns/1ps
module tb_wishbone_sram_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat_w;
  logic [3:0]  sel;
  logic        we, cyc, stb, tgt;
  logic        cyc_a, cyc_b;
  logic [31:0] dat_r_a, dat_r_b, dat_r_m;
  logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;
  logic        ack_m, err_m, busy_m;

  int tests = 0;
  int fails = 0;
  bit [31:0] model [int];

  always #5 clk = ~clk;

  assign cyc_a   = cyc & !tgt;
  assign cyc_b   = cyc & tgt;
  assign ack_m   = tgt ? ack_b : ack_a;
  assign err_m   = tgt ? err_b : err_a;
  assign dat_r_m = tgt ? dat_r_b : dat_r_a;
  assign busy_m  = tgt ? busy_b : busy_a;

  wishbone_sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .wb_adr(adr), .wb_dat_w(dat_w), .wb_sel(sel), .wb_we(we),
    .wb_cyc(cyc_a), .wb_stb(stb), .wb_dat_r(dat_r_a), .wb_ack(ack_a), .wb_err(err_a),
    .busy(busy_a));

  wishbone_sram_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .wb_adr(adr), .wb_dat_w(dat_w), .wb_sel(sel), .wb_we(we),
    .wb_cyc(cyc_b), .wb_stb(stb), .wb_dat_r(dat_r_b), .wb_ack(ack_b), .wb_err(err_b),
    .busy(busy_b));

  function automatic bit addr_ok(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off / 4) < DEPTH;
  endfunction

  function automatic int addr_idx(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off / 4);
  endfunction

  // Model of a completed write: only selected byte lanes change, only in range.
  function automatic void model_write(int m, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    bit [31:0] w;
    int key;
    if (!addr_ok(a)) return;
    key = m * 4096 + addr_idx(a);
    w = model.exists(key) ? model[key] : 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    model[key] = w;
  endfunction

  // Single transaction on the selected instance; lat counts cycles from the capture edge.
  task automatic xfer(input logic t, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic got_ack, output logic got_err,
                      output logic [31:0] rdata, output int lat, output logic glitch);
    @(negedge clk);
    tgt = t; we = w; adr = a; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1 stb = 1'b0;
    got_ack = 1'b0; got_err = 1'b0; rdata = '0; lat = -1; glitch = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (ack_m && err_m) glitch = 1'b1;
      if (!ack_m && dat_r_m !== 32'h0) glitch = 1'b1;
      if (ack_m || err_m) begin
        got_ack = ack_m; got_err = err_m; rdata = dat_r_m; lat = k;
        break;
      end
    end
    cyc = 1'b0;
    @(negedge clk);
    if (ack_m || err_m || dat_r_m !== 32'h0) glitch = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; tgt = 1'b0;
    adr = '0; dat_w = '0; sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (ack_a !== 1'b0) begin fails++; $display("FAIL reset_ack got=%b exp=0", ack_a); end
    tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err_a); end
    tests++; if (dat_r_a !== 32'h0) begin fails++; $display("FAIL reset_dat got=%h exp=0", dat_r_a); end
    tests++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b%b exp=00", busy_a, busy_b); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic a, e, g; logic [31:0] r; int l;
    xfer(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, a, e, r, l, g);
    model_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    tests++; if (a !== 1'b1 || e !== 1'b0 || l != 3) begin fails++; $display("FAIL wr_resp ack=%b err=%b lat=%0d exp ack=1 err=0 lat=3", a, e, l); end
    xfer(0, 0, 32'h8000_0010, 32'h0, 4'h0, a, e, r, l, g);
    tests++; if (a !== 1'b1 || e !== 1'b0 || l != 3) begin fails++; $display("FAIL rd_resp ack=%b err=%b lat=%0d exp ack=1 err=0 lat=3", a, e, l); end
    tests++; if (r !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data got=%h exp=deadbeef", r); end
    tests++; if (g !== 1'b0) begin fails++; $display("FAIL rd_glitch got=%b exp=0", g); end
  endtask

  task automatic test_random();
    logic a, e, g; logic [31:0] r, ad, d; logic [3:0] s; logic w; int l;
    int idx [8];
    int nbad;
    nbad = 0;
    for (int i = 0; i < 8; i++) begin
      idx[i] = int'($urandom_range(0, DEPTH - 1));
      d = $urandom;
      ad = BASE + 32'(idx[i]) * 4;
      xfer(0, 1, ad, d, 4'hF, a, e, r, l, g);
      model_write(0, ad, d, 4'hF);
    end
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom);
      d = $urandom;
      if ($urandom_range(0, 5) == 0)
        ad = ($urandom_range(0, 1) == 1) ? (BASE + 32'h1000 + ($urandom & 32'h0FFF_FFFC))
                                         : (BASE - 32'h4 - ($urandom & 32'h0FFF_FFFC));
      else
        ad = BASE + 32'(idx[$urandom_range(0, 7)]) * 4;
      xfer(0, w, ad, d, s, a, e, r, l, g);
      if (w) model_write(0, ad, d, s);
      if (a !== addr_ok(ad) || e !== !addr_ok(ad) || l != 3 || g !== 1'b0) nbad++;
      if (!w && addr_ok(ad) && r !== model[addr_idx(ad)]) nbad++;
      if (!w && !addr_ok(ad) && r !== 32'h0) nbad++;
    end
    tests++; if (nbad != 0) begin fails++; $display("FAIL random_ops bad=%0d exp=0", nbad); end
  endtask

  task automatic test_byte_lanes();
    logic a, e, g; logic [31:0] r; int l;
    xfer(0, 1, 32'h8000_0040, 32'h1122_3344, 4'hF, a, e, r, l, g);
    xfer(0, 1, 32'h8000_0040, 32'hAABB_CCDD, 4'b0101, a, e, r, l, g);
    xfer(0, 0, 32'h8000_0040, 32'h0, 4'h0, a, e, r, l, g);
    tests++; if (r !== 32'h11BB_33DD) begin fails++; $display("FAIL byte_lanes got=%h exp=11bb33dd", r); end
    xfer(0, 1, 32'h8000_0040, 32'hFFFF_FFFF, 4'h0, a, e, r, l, g);
    tests++; if (a !== 1'b1 || e !== 1'b0) begin fails++; $display("FAIL sel0_ack ack=%b err=%b exp ack=1 err=0", a, e); end
    xfer(0, 0, 32'h8000_0040, 32'h0, 4'h3, a, e, r, l, g);
    tests++; if (r !== 32'h11BB_33DD) begin fails++; $display("FAIL sel0_unchanged got=%h exp=11bb33dd", r); end
  endtask

  task automatic test_out_of_range();
    logic a, e, g; logic [31:0] r; int l;
    xfer(0, 1, 32'h8000_0000, 32'h5A5A_0001, 4'hF, a, e, r, l, g);
    xfer(0, 0, 32'h8000_1000, 32'h0, 4'hF, a, e, r, l, g);
    tests++; if (e !== 1'b1 || a !== 1'b0 || r !== 32'h0 || l != 3 || g !== 1'b0) begin fails++; $display("FAIL oor_high ack=%b err=%b dat=%h lat=%0d exp 0/1/0/3", a, e, r, l); end
    xfer(0, 0, 32'h7FFF_FFFC, 32'h0, 4'hF, a, e, r, l, g);
    tests++; if (e !== 1'b1 || a !== 1'b0 || r !== 32'h0 || g !== 1'b0) begin fails++; $display("FAIL oor_low ack=%b err=%b dat=%h exp 0/1/0", a, e, r); end
    xfer(0, 1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, a, e, r, l, g);
    tests++; if (e !== 1'b1 || a !== 1'b0) begin fails++; $display("FAIL oor_wr ack=%b err=%b exp 0/1", a, e); end
    xfer(0, 0, 32'h8000_0000, 32'h0, 4'hF, a, e, r, l, g);
    tests++; if (r !== 32'h5A5A_0001) begin fails++; $display("FAIL oor_wr_mem got=%h exp=5a5a0001", r); end
  endtask

  task automatic test_abort();
    logic a, e, g; logic [31:0] r; int l; int resp;
    xfer(0, 1, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, a, e, r, l, g);
    @(negedge clk);
    tgt = 1'b0; we = 1'b1; adr = 32'h8000_0020; dat_w = 32'h1234_5678; sel = 4'hF;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL abort_busy_wait got=%b exp=1", busy_a); end
    @(negedge clk);
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL abort_busy_fall got=%b exp=0", busy_a); end
    resp = 0;
    for (int k = 0; k < 5; k++) begin
      if (ack_a || err_a) resp++;
      @(negedge clk);
    end
    tests++; if (resp != 0) begin fails++; $display("FAIL abort_noresp got=%0d exp=0", resp); end
    xfer(0, 0, 32'h8000_0020, 32'h0, 4'hF, a, e, r, l, g);
    tests++; if (r !== 32'h0BAD_F00D) begin fails++; $display("FAIL abort_mem got=%h exp=0badf00d", r); end
  endtask

  task automatic test_reset_mid();
    logic a, e, g; logic [31:0] r; int l; int resp;
    xfer(0, 1, 32'h8000_0030, 32'hCAFE_0030, 4'hF, a, e, r, l, g);
    @(negedge clk);
    tgt = 1'b0; we = 1'b1; adr = 32'h8000_0030; dat_w = 32'h0000_0000; sel = 4'hF;
    cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1 stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if (ack_a !== 1'b0 || err_a !== 1'b0 || busy_a !== 1'b0) begin fails++; $display("FAIL rst_mid ack=%b err=%b busy=%b exp 000", ack_a, err_a, busy_a); end
    rst = 1'b0; cyc = 1'b0;
    resp = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ack_a || err_a) resp++;
    end
    tests++; if (resp != 0) begin fails++; $display("FAIL rst_mid_noresp got=%0d exp=0", resp); end
    xfer(0, 0, 32'h8000_0030, 32'h0, 4'hF, a, e, r, l, g);
    tests++; if (r !== 32'hCAFE_0030 || a !== 1'b1 || l != 3) begin fails++; $display("FAIL rst_mid_after dat=%h ack=%b lat=%0d exp cafe0030/1/3", r, a, l); end
  endtask

  task automatic test_back_to_back();
    logic a, e, g; logic [31:0] r; int l;
    logic [31:0] wd [4];
    logic [31:0] wa [4];
    int nbad;
    nbad = 0;
    for (int i = 0; i < 4; i++) begin
      wa[i] = BASE + 32'h100 + 32'(i) * 8;
      wd[i] = $urandom;
      xfer(1, 1, wa[i], wd[i], 4'hF, a, e, r, l, g);
      if (a !== 1'b1 || l != 1) nbad++;
    end
    tests++; if (nbad != 0) begin fails++; $display("FAIL ws0_write bad=%0d exp=0", nbad); end
    @(negedge clk);
    tgt = 1'b1; we = 1'b0; adr = wa[0]; sel = 4'h0; cyc = 1'b1; stb = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tests++;
      if (ack_b !== 1'(k % 2) || err_b !== 1'b0) begin
        fails++; $display("FAIL b2b_ack k=%0d ack=%b err=%b exp ack=%0d err=0", k, ack_b, err_b, k % 2);
      end
      if (k % 2 == 1) begin
        tests++;
        if (dat_r_b !== wd[k/2]) begin fails++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, dat_r_b, wd[k/2]); end
        if (k < 7) adr = wa[k/2 + 1];
      end
    end
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    tests++; if (ack_b !== 1'b0 || busy_b !== 1'b0) begin fails++; $display("FAIL b2b_end ack=%b busy=%b exp 00", ack_b, busy_b); end
    tgt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
